alu_output_monitor: RTL and testbench
=====================================

Name: alu_output_monitor

Overview:
- Downstream checker for the 8-bit ALU under test. It accepts each ALU transaction (operands, opcode, DUT result and zero flag) over a valid/ready handshake.
- It recomputes the expected result with a 2-stage golden pipeline and counts mismatches.
- It captures the first mismatching transaction and raises a sticky alarm at a threshold.
- It sits between the ALU and the Trojan-detection scoreboard/bench.

Parameters:
- WIDTH, 8, operand/result width
- CNT_W, 16, width of txn_count and mismatch_count
- ALARM_THRESH, 1, mismatch count at which alarm asserts (1..2^CNT_W-1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  monitoring enable
- clear  in  1  synchronous soft clear
- in_valid  in  1  transaction valid
- in_ready  out  1  monitor can accept
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- opcode  in  2  ALU opcode
- dut_y  in  WIDTH  DUT result
- dut_zero  in  1  DUT zero flag
- mismatch_pulse  out  1  one-cycle pulse per detected mismatch
- alarm  out  1  sticky alarm
- txn_count  out  CNT_W  accepted transactions, saturating
- mismatch_count  out  CNT_W  mismatches, saturating
- cap_valid  out  1  capture registers hold a mismatch
- cap_a, cap_b  out  WIDTH  operands of first mismatch
- cap_opcode  out  2  opcode of first mismatch
- cap_dut_y, cap_exp_y  out  WIDTH  DUT and expected result of first mismatch

Behaviour:
- Reset (async, rst=1):
  - All outputs are 0, except in_ready, which follows the state.
  - State is IDLE and all pipeline valids are 0.
- Accept rule: a transaction is accepted when in_valid & in_ready at a rising edge. in_ready = 1 in MONITOR and ALARM, 0 in IDLE. No backpressure beyond that.
- Golden model, all arithmetic modulo 2^WIDTH:
  - 00 = a+b
  - 01 = a-b
  - 10 = a&b
  - 11 = a|b
- Pipeline:
  - S1 registers the inputs plus a valid bit.
  - S2 registers expected y and the mismatch bit (dut_y != exp_y).
  - For acceptance at edge E0, mismatch_pulse, the counter updates and the capture are all visible after edge E2 (latency 2). One transaction per cycle is sustained.
- txn_count increments at acceptance (E0). Both counters saturate at 2^CNT_W-1 and never wrap.
- Capture: loaded only on the first mismatch (cap_valid 0->1). It is frozen until clear or rst.
- FSM (IDLE, MONITOR, ALARM):
  - IDLE->MONITOR when enable=1.
  - MONITOR->IDLE when enable=0. In-flight S1/S2 transactions still complete and count.
  - MONITOR->ALARM on the edge where mismatch_count becomes >= ALARM_THRESH.
  - ALARM is sticky: enable=0 does not leave it; only clear or rst does.
  - alarm = (state==ALARM).
- clear=1:
  - Zeroes counters, capture, cap_valid and pipeline valids; state goes to IDLE.
  - It has priority over a simultaneous acceptance or mismatch, which is discarded.
  - mismatch_pulse is 0 on the cycle after clear.
- Simultaneous acceptance and mismatch retirement in the same cycle: both counters update independently.
- rst asserted mid-stream: in-flight transactions are dropped with no pulse.

Optional Feature:
- Macro: ZERO_FLAG_CHECK_EN.
- When defined:
  - S2 also computes exp_zero = (exp_y==0).
  - mismatch = (dut_y!=exp_y) | (dut_zero!=exp_zero).
  - An extra output cap_dut_zero (1 bit) captures dut_zero on the first mismatch.
- When undefined: dut_zero is ignored (unused input), no cap_dut_zero port exists, and mismatch compares results only.

Decomposition:
- Package alu_mon_pkg: opcode constants (OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11) and state encodings (IDLE, MONITOR, ALARM).
- One sub-module: alu_golden_model (combinational, WIDTH-parameterised), instantiated at S2 input.

Test Plan:
- Normal traffic:
  - Stimulus: enable=1; op=00, a=8'h7F, b=8'h01, dut_y=8'h80.
  - Response: txn_count=1 after E0, no mismatch_pulse, mismatch_count=0, alarm=0.
- Trigger pattern:
  - Stimulus: op=11, a=8'hA5, b=8'h5A, dut_y=8'h00.
  - Response: mismatch_pulse at E2, mismatch_count=1, alarm=1 (THRESH=1).
  - Capture: cap_exp_y=8'hFF, cap_dut_y=8'h00, cap_valid=1.
  - A second mismatch leaves the capture unchanged.
- Saturation:
  - Stimulus: CNT_W=4, 20 back-to-back mismatching txns.
  - Response: mismatch_count and txn_count both stick at 15; no wrap.
- Clear vs mismatch:
  - Stimulus: clear asserted on the same edge a mismatch retires.
  - Response: counters=0, cap_valid=0, alarm=0, state IDLE, no pulse after.
- Reset mid-stream:
  - Stimulus: rst pulsed between acceptance (E0) and E2 of a mismatching txn.
  - Response: all outputs 0 immediately (async), no later mismatch_pulse.
- ZERO_FLAG_CHECK_EN:
  - Stimulus: op=10, a=8'h0F, b=8'hF0, dut_y=8'h00, dut_zero=0.
  - Response with macro defined: mismatch_pulse=1.
  - Response with macro undefined: no mismatch.

Source files
------------

// File: rtl/alu_mon_pkg.sv
// Shared definitions for the ALU output monitor: opcode encodings and FSM states.
package alu_mon_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        MONITOR = 2'b01,
        ALARM   = 2'b10
    } state_e;

endpackage

// File: rtl/alu_output_monitor_golden.sv
// Combinational reference ALU; all arithmetic wraps modulo 2^WIDTH.
module alu_golden_model
    import alu_mon_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       opcode,
    output logic [WIDTH-1:0] y
);

    // Select the reference result for the opcode.
    always_comb begin
        y = '0;
        case (opcode)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_output_monitor.sv
// ALU output monitor: accepts ALU transactions, recomputes the result in a
// 2-stage pipeline, counts mismatches, captures the first one and raises a
// sticky alarm at ALARM_THRESH mismatches.
// Optional: define ZERO_FLAG_CHECK_EN to also compare the DUT zero flag and
// expose cap_dut_zero.
module alu_output_monitor
    import alu_mon_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CNT_W        = 16,
    parameter int ALARM_THRESH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       opcode,
    input  logic [WIDTH-1:0] dut_y,
    input  logic             dut_zero,
    output logic             mismatch_pulse,
    output logic             alarm,
    output logic [CNT_W-1:0] txn_count,
    output logic [CNT_W-1:0] mismatch_count,
    output logic             cap_valid,
    output logic [WIDTH-1:0] cap_a,
    output logic [WIDTH-1:0] cap_b,
    output logic [1:0]       cap_opcode,
    output logic [WIDTH-1:0] cap_dut_y,
    output logic [WIDTH-1:0] cap_exp_y
`ifdef ZERO_FLAG_CHECK_EN
    ,
    output logic             cap_dut_zero
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THRESH  = CNT_W'(ALARM_THRESH);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [1:0]       opcode;
        logic [WIDTH-1:0] dut_y;
    } txn_t;

    state_e           state_q;
    logic             in_ready_q, alarm_q;
    logic             accept;

    logic             s1_vld_q, s1_vld_d;
    txn_t             s1_txn_q, s1_txn_d;
    logic             s2_vld_q, s2_vld_d;
    logic             s2_mis_q, s2_mis_d;
    txn_t             s2_txn_q, s2_txn_d;
    logic [WIDTH-1:0] s2_exp_y_q, s2_exp_y_d;
    logic [WIDTH-1:0] exp_y;
    logic             mis_now;

    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] txn_cnt_q, txn_cnt_d;
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;
    logic             cap_vld_q, cap_vld_d;
    txn_t             cap_txn_q, cap_txn_d;
    logic [WIDTH-1:0] cap_exp_q, cap_exp_d;

    assign accept = in_valid & in_ready_q;

    // Reference result for the transaction sitting in S1.
    alu_golden_model #(.WIDTH(WIDTH)) u_golden (
        .a      (s1_txn_q.a),
        .b      (s1_txn_q.b),
        .opcode (s1_txn_q.opcode),
        .y      (exp_y)
    );

`ifdef ZERO_FLAG_CHECK_EN
    logic s1_dz_q, s2_dz_q, cap_dz_q;
    logic cap_dz_d;

    // Zero-flag side pipeline, follows the main transaction stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_dz_q  <= 1'b0;
            s2_dz_q  <= 1'b0;
            cap_dz_q <= 1'b0;
        end else begin
            s1_dz_q  <= dut_zero;
            s2_dz_q  <= s1_dz_q;
            cap_dz_q <= cap_dz_d;
        end
    end

    // Zero flag captured alongside the first mismatch.
    always_comb begin
        cap_dz_d = cap_dz_q;
        if (clear)
            cap_dz_d = 1'b0;
        else if (pulse_d && !cap_vld_q)
            cap_dz_d = s2_dz_q;
    end

    assign mis_now      = (s1_txn_q.dut_y != exp_y) | (s1_dz_q != (exp_y == '0));
    assign cap_dut_zero = cap_dz_q;
`else
    logic unused_dut_zero;
    assign unused_dut_zero = dut_zero;
    assign mis_now         = (s1_txn_q.dut_y != exp_y);
`endif

    // Next-state for pipeline, counters and capture; clear overrides everything.
    always_comb begin
        s1_vld_d   = accept;
        s1_txn_d   = '{a: a, b: b, opcode: opcode, dut_y: dut_y};
        s2_vld_d   = s1_vld_q;
        s2_mis_d   = s1_vld_q & mis_now;
        s2_txn_d   = s1_txn_q;
        s2_exp_y_d = exp_y;
        pulse_d    = s2_vld_q & s2_mis_q;
        txn_cnt_d  = txn_cnt_q;
        mis_cnt_d  = mis_cnt_q;
        cap_vld_d  = cap_vld_q;
        cap_txn_d  = cap_txn_q;
        cap_exp_d  = cap_exp_q;

        if (accept && txn_cnt_q != CNT_MAX)
            txn_cnt_d = txn_cnt_q + 1'b1;
        if (pulse_d && mis_cnt_q != CNT_MAX)
            mis_cnt_d = mis_cnt_q + 1'b1;
        if (pulse_d && !cap_vld_q) begin
            cap_vld_d = 1'b1;
            cap_txn_d = s2_txn_q;
            cap_exp_d = s2_exp_y_q;
        end

        if (clear) begin
            s1_vld_d  = 1'b0;
            s2_vld_d  = 1'b0;
            s2_mis_d  = 1'b0;
            pulse_d   = 1'b0;
            txn_cnt_d = '0;
            mis_cnt_d = '0;
            cap_vld_d = 1'b0;
            cap_txn_d = '0;
            cap_exp_d = '0;
        end
    end

    // Pipeline, counter and capture registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s1_txn_q   <= '0;
            s2_vld_q   <= 1'b0;
            s2_mis_q   <= 1'b0;
            s2_txn_q   <= '0;
            s2_exp_y_q <= '0;
            pulse_q    <= 1'b0;
            txn_cnt_q  <= '0;
            mis_cnt_q  <= '0;
            cap_vld_q  <= 1'b0;
            cap_txn_q  <= '0;
            cap_exp_q  <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_txn_q   <= s1_txn_d;
            s2_vld_q   <= s2_vld_d;
            s2_mis_q   <= s2_mis_d;
            s2_txn_q   <= s2_txn_d;
            s2_exp_y_q <= s2_exp_y_d;
            pulse_q    <= pulse_d;
            txn_cnt_q  <= txn_cnt_d;
            mis_cnt_q  <= mis_cnt_d;
            cap_vld_q  <= cap_vld_d;
            cap_txn_q  <= cap_txn_d;
            cap_exp_q  <= cap_exp_d;
        end
    end

    // Monitor FSM with registered in_ready/alarm; ALARM only leaves on clear/rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else if (clear) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q    <= MONITOR;
                        in_ready_q <= 1'b1;
                    end
                end
                MONITOR: begin
                    if (mis_cnt_d >= THRESH) begin
                        state_q <= ALARM;
                        alarm_q <= 1'b1;
                    end else if (!enable) begin
                        state_q    <= IDLE;
                        in_ready_q <= 1'b0;
                    end
                end
                ALARM: begin
                    state_q <= ALARM;
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b0;
                    alarm_q    <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready       = in_ready_q;
    assign alarm          = alarm_q;
    assign mismatch_pulse = pulse_q;
    assign txn_count      = txn_cnt_q;
    assign mismatch_count = mis_cnt_q;
    assign cap_valid      = cap_vld_q;
    assign cap_a          = cap_txn_q.a;
    assign cap_b          = cap_txn_q.b;
    assign cap_opcode     = cap_txn_q.opcode;
    assign cap_dut_y      = cap_txn_q.dut_y;
    assign cap_exp_y      = cap_exp_q;

endmodule

// File: tb/tb_alu_output_monitor.sv
// Directed bench for alu_output_monitor: vector table plus hand sequences for
// saturation (CNT_W=4 instance), clear-vs-retire and reset mid-stream.
module tb_alu_output_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, enable, clear, in_valid;
    logic       s_enable, s_clear, s_valid;
    logic [7:0] a, b, dut_y;
    logic [1:0] opcode;
    logic       dut_zero;

    logic        in_ready, pulse, alarm, cap_valid;
    logic [15:0] txn_count, mis_count;
    logic [7:0]  cap_a, cap_b, cap_dut_y, cap_exp_y;
    logic [1:0]  cap_opcode;

    logic       s_ready, s_pulse, s_alarm, s_cap_valid;
    logic [3:0] s_txn, s_mis;
    logic [7:0] s_cap_a, s_cap_b, s_cap_dut_y, s_cap_exp_y;
    logic [1:0] s_cap_opcode;

`ifdef ZERO_FLAG_CHECK_EN
    logic cap_dut_zero, s_cap_dut_zero;
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    alu_output_monitor #(.WIDTH(8), .CNT_W(16), .ALARM_THRESH(1)) dut (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .opcode(opcode), .dut_y(dut_y), .dut_zero(dut_zero),
        .mismatch_pulse(pulse), .alarm(alarm),
        .txn_count(txn_count), .mismatch_count(mis_count),
        .cap_valid(cap_valid), .cap_a(cap_a), .cap_b(cap_b),
        .cap_opcode(cap_opcode), .cap_dut_y(cap_dut_y), .cap_exp_y(cap_exp_y)
`ifdef ZERO_FLAG_CHECK_EN
        , .cap_dut_zero(cap_dut_zero)
`endif
    );

    alu_output_monitor #(.WIDTH(8), .CNT_W(4), .ALARM_THRESH(1)) dut_sat (
        .clk(clk), .rst(rst), .enable(s_enable), .clear(s_clear),
        .in_valid(s_valid), .in_ready(s_ready),
        .a(a), .b(b), .opcode(opcode), .dut_y(dut_y), .dut_zero(dut_zero),
        .mismatch_pulse(s_pulse), .alarm(s_alarm),
        .txn_count(s_txn), .mismatch_count(s_mis),
        .cap_valid(s_cap_valid), .cap_a(s_cap_a), .cap_b(s_cap_b),
        .cap_opcode(s_cap_opcode), .cap_dut_y(s_cap_dut_y), .cap_exp_y(s_cap_exp_y)
`ifdef ZERO_FLAG_CHECK_EN
        , .cap_dut_zero(s_cap_dut_zero)
`endif
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
        logic       z;
        logic       mis;
    } vec_t;

    vec_t vecs[7];

    task automatic drive(input logic [1:0] op, input logic [7:0] va, input logic [7:0] vb,
                         input logic [7:0] vy, input logic vz);
        opcode = op; a = va; b = vb; dut_y = vy; dut_zero = vz;
    endtask

    int exp_txn, exp_mis, npulse;

    initial begin
        rst = 1'b1; enable = 1'b0; clear = 1'b0; in_valid = 1'b0;
        s_enable = 1'b0; s_clear = 1'b0; s_valid = 1'b0;
        drive(2'b00, 8'h00, 8'h00, 8'h00, 1'b0);

        //            op     a      b      dut_y  zero  mismatch
        vecs[0] = '{2'b00, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0};  // normal traffic
        vecs[1] = '{2'b00, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};  // add wraps to 0
        vecs[2] = '{2'b01, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0};  // sub wraps to FF
        vecs[3] = '{2'b10, 8'h3C, 8'h0F, 8'h0C, 1'b0, 1'b0};
        vecs[4] = '{2'b11, 8'hA5, 8'h5A, 8'h00, 1'b1, 1'b1};  // trigger, exp FF
        vecs[5] = '{2'b10, 8'h0F, 8'hF0, 8'h00, 1'b0, ZF};    // zero flag only
        vecs[6] = '{2'b00, 8'h01, 8'h01, 8'h03, 1'b0, 1'b1};  // second mismatch

        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 0);
        chk("rst_alarm", {31'b0, alarm}, 0);
        chk("rst_pulse", {31'b0, pulse}, 0);
        chk("rst_txn", {16'b0, txn_count}, 0);
        chk("rst_mis", {16'b0, mis_count}, 0);
        chk("rst_cap_valid", {31'b0, cap_valid}, 0);
        rst = 1'b0;

        // Saturation: 20 back-to-back mismatches into the CNT_W=4 instance.
        s_enable = 1'b1;
        @(negedge clk);
        chk("sat_ready", {31'b0, s_ready}, 1);
        drive(2'b00, 8'h01, 8'h01, 8'h00, 1'b1);
        s_valid = 1'b1;
        npulse = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (i == 19) s_valid = 1'b0;
            if (s_pulse) npulse++;
        end
        chk("sat_pulses", npulse, 20);
        chk("sat_txn", {28'b0, s_txn}, 15);
        chk("sat_mis", {28'b0, s_mis}, 15);
        chk("sat_alarm", {31'b0, s_alarm}, 1);
        chk("sat_cap_exp", {24'b0, s_cap_exp_y}, 8'h02);

        // Vector table on the main instance.
        enable = 1'b1;
        @(negedge clk);
        chk("mon_ready", {31'b0, in_ready}, 1);
        exp_txn = 0; exp_mis = 0;
        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].z);
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            exp_txn++;
            chk($sformatf("v%0d_txn", i), {16'b0, txn_count}, exp_txn);
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            if (vecs[i].mis) exp_mis++;
            chk($sformatf("v%0d_pulse", i), {31'b0, pulse}, {31'b0, vecs[i].mis});
            chk($sformatf("v%0d_mis", i), {16'b0, mis_count}, exp_mis);
            chk($sformatf("v%0d_alarm", i), {31'b0, alarm}, (exp_mis >= 1) ? 1 : 0);
        end
        // Capture must still hold the first mismatch (vector 4).
        chk("cap_valid", {31'b0, cap_valid}, 1);
        chk("cap_a", {24'b0, cap_a}, 8'hA5);
        chk("cap_b", {24'b0, cap_b}, 8'h5A);
        chk("cap_opcode", {30'b0, cap_opcode}, 2'b11);
        chk("cap_dut_y", {24'b0, cap_dut_y}, 8'h00);
        chk("cap_exp_y", {24'b0, cap_exp_y}, 8'hFF);
`ifdef ZERO_FLAG_CHECK_EN
        chk("cap_dut_zero", {31'b0, cap_dut_zero}, 1);
`endif
        // ALARM is sticky against enable=0.
        enable = 1'b0;
        @(negedge clk);
        chk("alarm_sticky", {31'b0, alarm}, 1);
        chk("alarm_ready", {31'b0, in_ready}, 1);
        enable = 1'b1;

        // Clear on the same edge that a mismatch retires.
        drive(2'b01, 8'h10, 8'h01, 8'h00, 1'b1);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        chk("clr_txn", {16'b0, txn_count}, 0);
        chk("clr_mis", {16'b0, mis_count}, 0);
        chk("clr_cap_valid", {31'b0, cap_valid}, 0);
        chk("clr_alarm", {31'b0, alarm}, 0);
        chk("clr_ready", {31'b0, in_ready}, 0);
        chk("clr_pulse", {31'b0, pulse}, 0);
        @(posedge clk);
        @(negedge clk);
        chk("clr_pulse_after", {31'b0, pulse}, 0);
        chk("clr_rearm", {31'b0, in_ready}, 1);

        // Reset between acceptance and retirement of a mismatching txn.
        drive(2'b00, 8'h02, 8'h02, 8'h05, 1'b0);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("rmid_txn_pre", {16'b0, txn_count}, 1);
        rst = 1'b1;
        #1;
        chk("rmid_txn", {16'b0, txn_count}, 0);
        chk("rmid_ready", {31'b0, in_ready}, 0);
        chk("rmid_alarm", {31'b0, alarm}, 0);
        #1 rst = 1'b0;
        npulse = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (pulse) npulse++;
        end
        chk("rmid_no_pulse", npulse, 0);
        chk("rmid_mis", {16'b0, mis_count}, 0);
        chk("rmid_cap_valid", {31'b0, cap_valid}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
